zif_cmd_sequencer: RTL and testbench

- Queues bottom-half commands and issues them one at a time to the OSC-domain command worker.
- Uses the toggle run/finish handshake: run = sync flag, finish = async flag, "running" = run XOR done.
- Inserts a programmable microsecond settle delay after each command completes.
- Sits between the bus write decoder (pushes, pre-synchronised to osc) and the per-chip command state machines.

---
 rtl/zif_seq_pkg.sv | 49 ++++
 rtl/zif_cmd_fifo.sv | 74 +++++++
 rtl/zif_cmd_sequencer.sv | 156 +++++++++++++++
 tb/tb_zif_cmd_sequencer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zif_seq_pkg.sv
// Shared types and constants for the command sequencer slice.
// Holds the FSM state encoding, the queue entry layout and the
// microsecond-to-cycle conversion used when arming the settle delay.
package zif_seq_pkg;

  // Oscillator cycles per microsecond (24 MHz osc).
  localparam int unsigned CYCLES_PER_US = 24;

  // Largest delay that fits the 16-bit settle counter at 24 cycles/us;
  // anything longer is clipped to 65535 cycles.
  localparam int unsigned MAX_DELAY_US = 2730;

  localparam int DELAY_CNT_WIDTH = 16;

  // Field widths of a queued command. The queue storage is built from
  // these, so the top-level width parameters must match them.
  localparam int SEQ_CMD_W = 4;
  localparam int SEQ_ARG_W = 8;
  localparam int SEQ_DLY_W = 12;

  typedef enum logic [1:0] {
    RESYNC,
    IDLE,
    WAIT_DONE,
    DELAY
  } seq_state_t;

  typedef struct packed {
    logic [SEQ_CMD_W-1:0] cmd;
    logic [SEQ_ARG_W-1:0] arg;
    logic [SEQ_DLY_W-1:0] delay_us;
  } cmd_entry_t;

  localparam int ENTRY_W = $bits(cmd_entry_t);

  // Settle time in osc cycles, saturated to the counter range.
  function automatic logic [DELAY_CNT_WIDTH-1:0] settle_cycles(
    input logic [SEQ_DLY_W-1:0] us,
    input int unsigned          cyc_per_us
  );
    logic [31:0] prod;
    prod = 32'(us) * 32'(cyc_per_us);
    if (prod > 32'((1 << DELAY_CNT_WIDTH) - 1)) begin
      return '1;
    end
    return prod[DELAY_CNT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/zif_cmd_fifo.sv
// Command queue: synchronous FIFO of packed command entries with flush.
// Latency: an entry pushed on edge k is visible at the head after edge k.
// Backpressure: pushes while full are ignored; the caller reports overflow.
// Ports: clk/rst, push/push_dat, pop, flush, head (combinational read of
// the oldest entry), full, empty, level (occupancy 0..DEPTH).
module zif_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = zif_seq_pkg::ENTRY_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign level = count;
  assign head  = mem[rd_ptr];

  // Flush wins over a same-cycle push, so the pushed entry is lost too.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/zif_cmd_sequencer.sv
// Queues bottom-half commands and issues them one at a time to the worker
// over a toggle run/done handshake, then waits a programmable settle time.
// Latency: push at edge k into an empty queue with FSM idle issues at k+1.
// Backpressure: push_ready low when full; a push while full is dropped and
// sets the sticky overflow flag.
// Ports: osc/rst; push_valid/push_cmd/push_arg/push_delay_us/push_ready;
// flush, clr_ovf; cmd_nr/cmd_arg/run_flag to the worker, done_flag back;
// busy, level, overflow status.
module zif_cmd_sequencer #(
  parameter int          QUEUE_DEPTH    = 4,
  parameter int          CMD_WIDTH      = zif_seq_pkg::SEQ_CMD_W,
  parameter int          ARG_WIDTH      = zif_seq_pkg::SEQ_ARG_W,
  parameter int unsigned CYCLES_PER_US  = zif_seq_pkg::CYCLES_PER_US,
  parameter int          DELAY_US_WIDTH = zif_seq_pkg::SEQ_DLY_W
) (
  input  logic                           osc,
  input  logic                           rst,
  input  logic                           push_valid,
  input  logic [CMD_WIDTH-1:0]           push_cmd,
  input  logic [ARG_WIDTH-1:0]           push_arg,
  input  logic [DELAY_US_WIDTH-1:0]      push_delay_us,
  output logic                           push_ready,
  input  logic                           flush,
  input  logic                           clr_ovf,
  output logic [CMD_WIDTH-1:0]           cmd_nr,
  output logic [ARG_WIDTH-1:0]           cmd_arg,
  output logic                           run_flag,
  input  logic                           done_flag,
  output logic                           busy,
  output logic [$clog2(QUEUE_DEPTH):0]   level,
  output logic                           overflow
);

  import zif_seq_pkg::*;

  localparam logic [DELAY_CNT_WIDTH-1:0] CNT_ONE = DELAY_CNT_WIDTH'(1);

  seq_state_t                  state;
  seq_state_t                  state_d;
  cmd_entry_t                  push_entry;
  cmd_entry_t                  head;
  logic                        q_full;
  logic                        q_empty;
  logic                        issue;
  logic                        load_cnt;
  logic [DELAY_US_WIDTH-1:0]   dly_us;
  logic [DELAY_CNT_WIDTH-1:0]  dly_cnt;

  assign push_entry = '{cmd: push_cmd, arg: push_arg, delay_us: push_delay_us};

  zif_cmd_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk      (osc),
    .rst      (rst),
    .push     (push_valid),
    .push_dat (push_entry),
    .pop      (issue),
    .flush    (flush),
    .head     (head),
    .full     (q_full),
    .empty    (q_empty),
    .level    (level)
  );

  // Gated by rst so the bus decoder never sees a ready queue while the
  // block is held in reset; busy likewise reads 0 during reset.
  assign push_ready = ~rst & ~q_full;
  assign busy       = ~rst & ((state != IDLE) | ~q_empty);

  // The worker's done flag arrives already in the osc domain, so the
  // handshake compares it directly: the worker is running while
  // run_flag and done_flag differ.
  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      state <= RESYNC;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d  = state;
    issue    = 1'b0;
    load_cnt = 1'b0;
    unique case (state)
      // A worker can still be finishing a command from before reset;
      // hold off until its done flag agrees with our run flag.
      RESYNC: begin
        if (done_flag == run_flag) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (!q_empty && !flush) begin
          issue   = 1'b1;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (done_flag == run_flag) begin
          if (dly_us == '0) begin
            state_d = IDLE;
          end else begin
            load_cnt = 1'b1;
            state_d  = DELAY;
          end
        end
      end
      DELAY: begin
        if (dly_cnt == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = RESYNC;
    endcase
  end

  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      cmd_nr   <= '0;
      cmd_arg  <= '0;
      run_flag <= 1'b0;
      dly_us   <= '0;
      dly_cnt  <= '0;
    end else begin
      if (issue) begin
        cmd_nr   <= head.cmd;
        cmd_arg  <= head.arg;
        dly_us   <= head.delay_us;
        run_flag <= ~run_flag;
      end
      // Loaded with N-1 so the FSM spends exactly N cycles in DELAY,
      // leaving on the edge that sees the counter at zero.
      if (load_cnt) begin
        dly_cnt <= settle_cycles(dly_us, CYCLES_PER_US) - CNT_ONE;
      end else if (state == DELAY && dly_cnt != '0) begin
        dly_cnt <= dly_cnt - CNT_ONE;
      end
    end
  end

  // Set has priority over clear; a push while full flags overflow even if
  // an entry leaves the queue on the same edge.
  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push_valid && q_full) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zif_cmd_sequencer.sv
module tb_zif_cmd_sequencer;
  import zif_seq_pkg::*;

  logic        osc = 1'b0;
  logic        rst = 1'b1;
  logic        push_valid = 1'b0;
  logic [3:0]  push_cmd = '0;
  logic [7:0]  push_arg = '0;
  logic [11:0] push_delay_us = '0;
  logic        push_ready;
  logic        flush = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [3:0]  cmd_nr;
  logic [7:0]  cmd_arg;
  logic        run_flag;
  logic        done_flag = 1'b0;
  logic        busy;
  logic [2:0]  level;
  logic        overflow;

  zif_cmd_sequencer dut (
    .osc           (osc),
    .rst           (rst),
    .push_valid    (push_valid),
    .push_cmd      (push_cmd),
    .push_arg      (push_arg),
    .push_delay_us (push_delay_us),
    .push_ready    (push_ready),
    .flush         (flush),
    .clr_ovf       (clr_ovf),
    .cmd_nr        (cmd_nr),
    .cmd_arg       (cmd_arg),
    .run_flag      (run_flag),
    .done_flag     (done_flag),
    .busy          (busy),
    .level         (level),
    .overflow      (overflow)
  );

  always #5 osc = ~osc;

  int cyc = 0;
  always @(posedge osc) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] cmd;
    logic [7:0] arg;
  } exp_t;
  exp_t sb[$];

  // Issue monitor: every run_flag toggle outside reset is one issued
  // command and must match the oldest expected entry.
  int   n_issue = 0;
  int   issue_cyc = 0;
  logic prev_run = 1'b0;
  exp_t mon_e;
  always @(negedge osc) begin
    if (rst) begin
      prev_run = run_flag;
    end else if (run_flag !== prev_run) begin
      prev_run  = run_flag;
      n_issue   = n_issue + 1;
      issue_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue got cmd=%0h arg=%0h want no issue", cmd_nr, cmd_arg);
      end else begin
        mon_e = sb.pop_front();
        if (cmd_nr !== mon_e.cmd || cmd_arg !== mon_e.arg) begin
          errors++;
          $display("FAIL issue_order got cmd=%0h arg=%0h want cmd=%0h arg=%0h",
                   cmd_nr, cmd_arg, mon_e.cmd, mon_e.arg);
        end
      end
    end
  end

  // Worker model: answers worker_lat edges after it sees a new run toggle.
  logic worker_en = 1'b0;
  logic worker_rst = 1'b0;
  int   worker_lat = 5;
  int   wcnt = 0;
  int   done_cyc = 0;
  always @(posedge osc) begin
    #1;
    if (worker_rst) begin
      done_flag = 1'b0;
      wcnt = 0;
    end else if (worker_en && run_flag !== done_flag) begin
      wcnt++;
      if (wcnt >= worker_lat) begin
        done_flag = run_flag;
        wcnt = 0;
        done_cyc = cyc;
      end
    end
  end

  task automatic push(input logic [3:0] c, input logic [7:0] a, input logic [11:0] d, input logic acc);
    exp_t e;
    push_valid = 1'b1; push_cmd = c; push_arg = a; push_delay_us = d;
    #2;
    checks++;
    if (push_ready !== acc) begin
      errors++;
      $display("FAIL push_ready cmd=%0h got=%b want=%b", c, push_ready, acc);
    end
    if (acc) begin
      e.cmd = c; e.arg = a;
      sb.push_back(e);
    end
    @(posedge osc); #1;
    push_valid = 1'b0;
  endtask

  task automatic wait_issues(input int n, input int budget);
    int b = 0;
    while (n_issue < n && b < budget) begin
      @(posedge osc); b++;
    end
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int b = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && b < budget) begin
      @(posedge osc); b++;
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({run_flag, cmd_nr, cmd_arg, busy, level, overflow, push_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got run=%b cmd=%0h arg=%0h busy=%b level=%0d ovf=%b rdy=%b want all 0",
               run_flag, cmd_nr, cmd_arg, busy, level, overflow, push_ready);
    end
    @(posedge osc); #1;
    rst = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL resync_busy got=%b want=1", busy);
    end
    @(posedge osc); #1;
    checks++;
    if (busy !== 1'b0 || push_ready !== 1'b1 || level !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_idle got busy=%b rdy=%b level=%0d want busy=0 rdy=1 level=0",
               busy, push_ready, level);
    end
  endtask

  task automatic test_basic();
    int k, n0, t;
    worker_en = 1'b1; worker_lat = 5; n0 = n_issue;
    push(4'd3, 8'h5A, 12'd0, 1'b1);
    k = cyc;
    wait_issues(n0 + 1, 20);
    checks++;
    if (n_issue !== n0 + 1 || issue_cyc !== k + 1) begin
      errors++;
      $display("FAIL issue_latency got edge=%0d issues=%0d want edge=%0d issues=%0d",
               issue_cyc, n_issue - n0, k + 1, 1);
    end
    checks++;
    if (cmd_nr !== 4'd3 || cmd_arg !== 8'h5A) begin
      errors++;
      $display("FAIL cmd_drive got cmd=%0h arg=%0h want cmd=3 arg=5a", cmd_nr, cmd_arg);
    end
    t = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge osc);
      if (busy === 1'b0) begin
        t = cyc;
        break;
      end
    end
    checks++;
    if (t !== k + 6) begin
      errors++;
      $display("FAIL busy_drop got edge=%0d want edge=%0d", t, k + 6);
    end
    checks++;
    if (cmd_nr !== 4'd3 || cmd_arg !== 8'h5A) begin
      errors++;
      $display("FAIL cmd_hold got cmd=%0h arg=%0h want cmd=3 arg=5a", cmd_nr, cmd_arg);
    end
    @(posedge osc); #1;
  endtask

  // exp_gap: edges from the worker's done toggle to the next issue, i.e.
  // one edge to leave WAIT_DONE, the DELAY cycles, one edge to issue.
  task automatic test_delay(input int dus, input int exp_gap, input int budget);
    int n0, dc0, d, b;
    worker_en = 1'b1; worker_lat = 5; n0 = n_issue; dc0 = done_cyc;
    push(4'h1, 8'h11, dus[11:0], 1'b1);
    push(4'h2, 8'h22, 12'd0, 1'b1);
    wait_issues(n0 + 1, 20);
    b = 0;
    while (done_cyc == dc0 && b < 20) begin
      @(posedge osc); b++;
    end
    d = done_cyc;
    wait_issues(n0 + 2, budget);
    checks++;
    if (n_issue !== n0 + 2 || issue_cyc - d !== exp_gap) begin
      errors++;
      $display("FAIL delay_%0dus got gap=%0d issues=%0d want gap=%0d issues=2",
               dus, issue_cyc - d, n_issue - n0, exp_gap);
    end
    wait_idle(50);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL delay_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_overflow();
    int n0;
    worker_en = 1'b0; n0 = n_issue;
    push(4'h0, 8'hA0, 12'd0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      push(4'(i + 3), 8'hA0 + 8'(i), 12'd0, 1'b1);
    end
    checks++;
    if (level !== 3'd4 || push_ready !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL queue_full got level=%0d rdy=%b ovf=%b want level=4 rdy=0 ovf=0",
               level, push_ready, overflow);
    end
    push(4'hF, 8'hFF, 12'd0, 1'b0);
    checks++;
    if (overflow !== 1'b1 || level !== 3'd4) begin
      errors++;
      $display("FAIL overflow_set got ovf=%b level=%0d want ovf=1 level=4", overflow, level);
    end
    clr_ovf = 1'b1;
    push(4'hE, 8'hEE, 12'd0, 1'b0);
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set_wins got=%b want=1", overflow);
    end
    clr_ovf = 1'b1;
    @(posedge osc); #1;
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear got=%b want=0", overflow);
    end
    worker_en = 1'b1; worker_lat = 3;
    wait_issues(n0 + 5, 200);
    wait_idle(50);
    checks++;
    if (n_issue !== n0 + 5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drain got issues=%0d busy=%b want issues=5 busy=0",
               n_issue - n0, busy);
    end
  endtask

  task automatic test_flush();
    int n0;
    worker_en = 1'b0; n0 = n_issue;
    push(4'h8, 8'h81, 12'd0, 1'b1);
    push(4'h9, 8'h82, 12'd0, 1'b1);
    push(4'hA, 8'h83, 12'd0, 1'b1);
    checks++;
    if (level !== 3'd2) begin
      errors++;
      $display("FAIL pre_flush_level got=%0d want=2", level);
    end
    void'(sb.pop_back());
    void'(sb.pop_back());
    flush = 1'b1;
    push_valid = 1'b1; push_cmd = 4'hD; push_arg = 8'hDD; push_delay_us = '0;
    @(posedge osc); #1;
    flush = 1'b0; push_valid = 1'b0;
    checks++;
    if (level !== 3'd0) begin
      errors++;
      $display("FAIL flush_level got=%0d want=0", level);
    end
    worker_en = 1'b1; worker_lat = 3;
    repeat (30) @(posedge osc);
    #1;
    checks++;
    if (n_issue !== n0 + 1 || busy !== 1'b0 || done_flag !== run_flag) begin
      errors++;
      $display("FAIL flush_no_issue got issues=%0d busy=%b want issues=1 busy=0",
               n_issue - n0, busy);
    end
  endtask

  task automatic test_back_to_back();
    int n0, nxt;
    worker_en = 1'b1; worker_lat = 5; n0 = n_issue;
    push(4'h1, 8'hC0, 12'd0, 1'b1);
    push(4'h2, 8'hC1, 12'd0, 1'b1);
    push(4'h3, 8'hC2, 12'd0, 1'b1);
    for (int j = 0; j < 8; j++) begin
      nxt = issue_cyc + worker_lat + 1;
      while (cyc < nxt - 1) begin
        @(posedge osc); #1;
      end
      push(4'(j + 4), 8'hB0 + 8'(j), 12'd0, 1'b1);
      checks++;
      if (level !== 3'd2) begin
        errors++;
        $display("FAIL b2b_level iter=%0d got=%0d want=2", j, level);
      end
      @(posedge osc); #1;
      checks++;
      if (issue_cyc !== nxt) begin
        errors++;
        $display("FAIL b2b_pop_edge iter=%0d got=%0d want=%0d", j, issue_cyc, nxt);
      end
    end
    wait_issues(n0 + 11, 200);
    wait_idle(50);
    checks++;
    if (n_issue !== n0 + 11 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got issues=%0d busy=%b want issues=11 busy=0", n_issue - n0, busy);
    end
  endtask

  task automatic test_reset_mid();
    int n0, dc0, b;
    worker_en = 1'b1; worker_lat = 3; n0 = n_issue; dc0 = done_cyc;
    push(4'h9, 8'hC3, 12'd5, 1'b1);
    wait_issues(n0 + 1, 20);
    b = 0;
    while (done_cyc == dc0 && b < 20) begin
      @(posedge osc); b++;
    end
    #1;
    worker_en = 1'b0;
    @(posedge osc); #1;
    rst = 1'b1;
    #2;
    checks++;
    if ({run_flag, cmd_nr, cmd_arg, busy, level, overflow, push_ready} !== '0 || done_flag !== 1'b1) begin
      errors++;
      $display("FAIL midrst_outputs got run=%b cmd=%0h arg=%0h busy=%b level=%0d ovf=%b rdy=%b done=%b want 0s done=1",
               run_flag, cmd_nr, cmd_arg, busy, level, overflow, push_ready, done_flag);
    end
    @(posedge osc); #1;
    rst = 1'b0;
    push(4'hB, 8'h3C, 12'd0, 1'b1);
    repeat (10) @(posedge osc);
    #1;
    checks++;
    if (n_issue !== n0 + 1 || level !== 3'd1 || busy !== 1'b1 || run_flag !== 1'b0) begin
      errors++;
      $display("FAIL resync_hold got issues=%0d level=%0d busy=%b run=%b want issues=1 level=1 busy=1 run=0",
               n_issue - n0, level, busy, run_flag);
    end
    worker_rst = 1'b1;
    repeat (2) @(posedge osc);
    #1;
    worker_rst = 1'b0; worker_en = 1'b1;
    wait_issues(n0 + 2, 20);
    wait_idle(50);
    checks++;
    if (n_issue !== n0 + 2 || cmd_nr !== 4'hB || busy !== 1'b0) begin
      errors++;
      $display("FAIL resync_release got issues=%0d cmd=%0h busy=%b want issues=2 cmd=b busy=0",
               n_issue - n0, cmd_nr, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay(2, 2 * 24 + 2, 200);
    test_overflow();
    test_flush();
    test_back_to_back();
    test_delay(3000, ((3000 > MAX_DELAY_US) ? 65535 : 3000 * 24) + 2, 70000);
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
